// File: rtl/pe_pkg.sv
// Shared PE definitions: sequencer state encoding, default widths and the
// activation beat carried through the output buffer.
package pe_pkg;

    localparam int PE_DW = 8;
    localparam int PE_AW = 4;
    localparam int PE_RW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        FILL  = 3'd2,
        RUN   = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    // eoj marks the final activation of the job
    typedef struct packed {
        logic [PE_DW-1:0] data;
        logic             last;
        logic             eoj;
    } act_beat_t;

endpackage

// File: rtl/ifmap_act_fifo.sv
// Two-entry activation buffer between the spad read port and the MAC stream;
// the window flags travel with each data word.
import pe_pkg::*;

module ifmap_act_fifo #(
    parameter int DW = PE_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          push_eoj,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic          head_eoj,
    output logic [1:0]    count
);

    act_beat_t mem [2];
    logic      rd_ptr;
    logic      wr_ptr;
    logic      pop_ok;

    assign valid     = (count != 2'd0);
    assign pop_ok    = pop && valid;
    assign head_data = mem[rd_ptr].data;
    assign head_last = mem[rd_ptr].last;
    assign head_eoj  = mem[rd_ptr].eoj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: push_data, last: push_last, eoj: push_eoj};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    // The read-issue throttle in the sequencer keeps this from ever overflowing
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop_ok && count == 2'd2));

endmodule

// File: rtl/ifmap_spad_ctrl.sv
// Ifmap scratchpad sequencer: fill one row, then replay sliding windows to the MAC.
// IFMAP_SPAD_CTRL_PERF_EN adds stall / fill-gap performance counters.
import pe_pkg::*;

module ifmap_spad_ctrl #(
    parameter int DW = PE_DW,
    parameter int AW = PE_AW,
    parameter int RW = PE_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   cfg_width,
    input  logic [AW:0]   cfg_filt,
    input  logic [RW-1:0] cfg_reps,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          spad_wr,
    output logic          spad_rd,
    output logic [AW-1:0] spad_addr,
    output logic [DW-1:0] spad_wdata,
    input  logic [DW-1:0] spad_rdata,
    output logic [DW-1:0] act_data,
    output logic          act_valid,
    input  logic          act_ready,
    output logic          act_last,
    output logic          act_end,
    output logic [2:0]    dbg_state
`ifdef IFMAP_SPAD_CTRL_PERF_EN
    ,
    output logic [15:0]   perf_stall,
    output logic [15:0]   perf_fill
`endif
);

    // Stream handshakes (fill input and activation output): a beat transfers
    // on any rising edge where valid and ready are both high; a valid beat
    // holds its payload until it transfers.

    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    state_t        state_q, state_d;
    logic [AW:0]   w_q, s_q;
    logic [RW-1:0] r_cfg_q;
    logic [AW-1:0] wcnt_q, p_q, k_q;
    logic [RW-1:0] r_q;
    logic          infl_q, infl_last_q, infl_eoj_q;
    logic [1:0]    buf_cnt;
    logic [2:0]    occ;
    logic          accept, cfg_ok, pop;
    logic          fill_last, k_last, p_last, r_last, rd_last;

    assign accept    = start && (state_q == IDLE);
    assign cfg_ok    = (w_q != '0) && (w_q <= DEPTH) && (s_q != '0) && (s_q <= w_q) && (r_cfg_q != '0);
    assign pop       = act_valid && act_ready;
    assign occ       = {1'b0, buf_cnt} + {2'b0, infl_q} - {2'b0, pop};
    assign fill_last = ({1'b0, wcnt_q} == w_q - 1'b1);
    assign k_last    = ({1'b0, k_q} == s_q - 1'b1);
    assign p_last    = ({1'b0, p_q} == w_q - s_q);
    assign r_last    = (r_q == r_cfg_q - 1'b1);
    assign rd_last   = k_last && p_last && r_last;

    assign busy       = (state_q == CHECK) || (state_q == FILL) || (state_q == RUN) || (state_q == FLUSH);
    assign done       = (state_q == DONE);
    assign in_ready   = (state_q == FILL);
    assign spad_wr    = in_ready && in_valid;
    assign spad_rd    = (state_q == RUN) && (occ < 3'd2);
    assign spad_wdata = in_data;
    assign dbg_state  = state_q;

    always_comb begin
        spad_addr = '0;
        if (state_q == FILL)
            spad_addr = wcnt_q;
        else if (state_q == RUN)
            spad_addr = p_q + k_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = CHECK;
            CHECK: state_d = cfg_ok ? FILL : DONE;
            FILL:  if (spad_wr && fill_last) state_d = RUN;
            RUN:   if (spad_rd && rd_last) state_d = FLUSH;
            // Leave as soon as the last buffered beat is accepted this cycle
            FLUSH: if (!infl_q && (buf_cnt == 2'd0 || (buf_cnt == 2'd1 && pop))) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q     <= '0;
            s_q     <= '0;
            r_cfg_q <= '0;
            cfg_err <= 1'b0;
        end else if (accept) begin
            w_q     <= cfg_width;
            s_q     <= cfg_filt;
            r_cfg_q <= cfg_reps;
            cfg_err <= 1'b0;
        end else if (state_q == CHECK && !cfg_ok) begin
            cfg_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            p_q    <= '0;
            k_q    <= '0;
            r_q    <= '0;
        end else if (accept) begin
            wcnt_q <= '0;
            p_q    <= '0;
            k_q    <= '0;
            r_q    <= '0;
        end else begin
            if (spad_wr)
                wcnt_q <= wcnt_q + 1'b1;
            if (spad_rd) begin
                k_q <= k_last ? '0 : k_q + 1'b1;
                if (k_last) begin
                    p_q <= p_last ? '0 : p_q + 1'b1;
                    if (p_last)
                        r_q <= r_q + 1'b1;
                end
            end
        end
    end

    // Flags for the read in flight; its data lands one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_eoj_q  <= 1'b0;
        end else begin
            infl_q      <= spad_rd;
            infl_last_q <= k_last;
            infl_eoj_q  <= rd_last;
        end
    end

    ifmap_act_fifo #(.DW(DW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl_q),
        .push_data (spad_rdata),
        .push_last (infl_last_q),
        .push_eoj  (infl_eoj_q),
        .pop       (pop),
        .valid     (act_valid),
        .head_data (act_data),
        .head_last (act_last),
        .head_eoj  (act_end),
        .count     (buf_cnt)
    );

`ifdef IFMAP_SPAD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
            perf_fill  <= '0;
        end else if (accept) begin
            perf_stall <= '0;
            perf_fill  <= '0;
        end else begin
            if (act_valid && !act_ready && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
            if (state_q == FILL && !in_valid && perf_fill != 16'hFFFF)
                perf_fill <= perf_fill + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// Directed bench for ifmap_spad_ctrl with a behavioural spad and an activation scoreboard.
module tb_ifmap_spad_ctrl;
  import pe_pkg::*;

  logic       clk, rst_n, start;
  logic [4:0] cfg_width, cfg_filt;
  logic [3:0] cfg_reps;
  logic       busy, done, cfg_err;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic       spad_wr, spad_rd;
  logic [3:0] spad_addr;
  logic [7:0] spad_wdata, spad_rdata;
  logic [7:0] act_data;
  logic       act_valid, act_ready, act_last, act_end;
  logic [2:0] dbg_state;
`ifdef IFMAP_SPAD_CTRL_PERF_EN
  logic [15:0] perf_stall, perf_fill;
`endif

  ifmap_spad_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_width(cfg_width), .cfg_filt(cfg_filt), .cfg_reps(cfg_reps),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .spad_wr(spad_wr), .spad_rd(spad_rd), .spad_addr(spad_addr),
    .spad_wdata(spad_wdata), .spad_rdata(spad_rdata),
    .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready),
    .act_last(act_last), .act_end(act_end), .dbg_state(dbg_state)
`ifdef IFMAP_SPAD_CTRL_PERF_EN
    , .perf_stall(perf_stall), .perf_fill(perf_fill)
`endif
  );

  // ---------------- clock / reset / spad model ----------------
  int cyc = 0;
  logic [7:0] mem [16];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (spad_wr) mem[spad_addr] <= spad_wdata;
    if (spad_rd) spad_rdata <= mem[spad_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  logic [7:0] fill_d [16];
  int total = 0, bad = 0;
  int beats, extra, wr_cnt, rd_cnt, both_viol, acc_viol, addr_viol, stable_viol;
  int stall_cnt, gap_cnt, last_end_cyc, done_cyc;
  int rdy_mode = 0;
  logic       prev_stall;
  logic [9:0] prev_beat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    prev_stall = 0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (spad_wr && spad_rd) both_viol++;
        if ((spad_wr || spad_rd) && dbg_state != 3'(FILL) && dbg_state != 3'(RUN)) acc_viol++;
        if (spad_wr) begin
          if (spad_addr != 4'(wr_cnt)) addr_viol++;
          wr_cnt++;
        end
        if (spad_rd) rd_cnt++;
        if (prev_stall && (!act_valid || {act_end, act_last, act_data} != prev_beat)) stable_viol++;
        prev_stall = act_valid && !act_ready;
        prev_beat = {act_end, act_last, act_data};
        if (act_valid && !act_ready) stall_cnt++;
        if (in_ready && !in_valid) gap_cnt++;
        if (act_valid && act_ready) begin
          beats++;
          if (act_end) last_end_cyc = cyc;
          if (exp_q.size() == 0) extra++;
          else check("beat", {22'd0, act_end, act_last, act_data}, {22'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // act_ready driver: 0 = always ready, 1 = toggling 1010...
  initial begin
    act_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) act_ready = ~act_ready;
      else act_ready = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_beat(input logic [7:0] d, input logic last, input logic eoj);
    exp_q.push_back({eoj, last, d});
  endtask

  task automatic load_model(input int w, input int s, input int r);
    for (int rr = 0; rr < r; rr++)
      for (int p = 0; p <= w - s; p++)
        for (int k = 0; k < s; k++)
          push_beat(fill_d[p+k], k == s-1, (rr == r-1) && (p == w-s) && (k == s-1));
  endtask

  task automatic start_job(input int w, input int s, input int r);
    beats = 0; extra = 0; wr_cnt = 0; rd_cnt = 0; both_viol = 0; acc_viol = 0;
    addr_viol = 0; stable_viol = 0; stall_cnt = 0; gap_cnt = 0; last_end_cyc = -100;
    @(posedge clk);
    #1;
    start = 1; cfg_width = 5'(w); cfg_filt = 5'(s); cfg_reps = 4'(r);
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic fill(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t;
      if (gaps && i[0]) begin
        in_valid = 0;
        @(posedge clk);
        #1;
      end
      in_valid = 1;
      in_data = fill_d[i];
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 50) break;
      end
      check("fill_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 0;
    end
  endtask

  task automatic wait_done(input logic exp_err);
    int t = 0;
    forever begin
      @(negedge clk);
      if (done || t > 3000) break;
      t++;
    end
    check("done_seen", done, 1);
    check("cfg_err", cfg_err, exp_err);
    check("busy_at_done", busy, 0);
    done_cyc = cyc;
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  task automatic end_checks(input int nbeats, input int nwr);
    check("beat_count", beats, nbeats);
    check("extra_beats", extra, 0);
    check("exp_left", exp_q.size(), 0);
    check("wr_count", wr_cnt, nwr);
    check("rd_count", rd_cnt, nbeats);
    check("wr_rd_both", both_viol, 0);
    check("access_state", acc_viol, 0);
    check("wr_addr", addr_viol, 0);
    check("stall_stable", stable_viol, 0);
  endtask

  task automatic load_t1;
    fill_d[0] = 8'd10; fill_d[1] = 8'd20; fill_d[2] = 8'd30; fill_d[3] = 8'd40;
    push_beat(8'd10, 0, 0); push_beat(8'd20, 0, 0); push_beat(8'd30, 1, 0);
    push_beat(8'd20, 0, 0); push_beat(8'd30, 0, 0); push_beat(8'd40, 1, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 0; start = 0; cfg_width = 0; cfg_filt = 0; cfg_reps = 0;
    in_data = 0; in_valid = 0; spad_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_act_valid", act_valid, 0);
    check("rst_spad", {spad_wr, spad_rd, spad_addr}, 0);

    // 1: basic job, always ready
    load_t1();
    start_job(4, 3, 1);
    fill(4, 0);
    wait_done(0);
    check("t1_done_lag", done_cyc - last_end_cyc, 1);
    end_checks(6, 4);

    // 2: same job with toggling ready
    rdy_mode = 1;
    load_t1();
    start_job(4, 3, 1);
    fill(4, 0);
    wait_done(0);
    check("t2_done_lag", done_cyc - last_end_cyc, 1);
    end_checks(6, 4);
`ifdef IFMAP_SPAD_CTRL_PERF_EN
    check("t2_perf_stall", perf_stall, stall_cnt);
`endif

    // 3a: full-depth single window, two passes
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) fill_d[i] = 8'(i * 3 + 1);
    load_model(16, 16, 2);
    start_job(16, 16, 2);
    fill(16, 0);
    wait_done(0);
    end_checks(32, 16);

    // 3b: single-tap filter, every beat is last
    for (int i = 0; i < 5; i++) fill_d[i] = 8'(8'hA0 + i);
    load_model(5, 1, 1);
    start_job(5, 1, 1);
    fill(5, 0);
    wait_done(0);
    end_checks(5, 5);

    // 4: illegal configs terminate two cycles after start without spad access
    start_job(4, 5, 1);
    @(negedge clk);
    check("t4a_busy", busy, 1);
    check("t4a_done_early", done, 0);
    @(negedge clk);
    check("t4a_done", done, 1);
    check("t4a_err", cfg_err, 1);
    check("t4a_access", wr_cnt + rd_cnt, 0);
    @(negedge clk);
    check("t4a_err_hold", cfg_err, 1);
    start_job(4, 3, 0);
    @(negedge clk);
    check("t4b_err_clr", cfg_err, 0);
    @(negedge clk);
    check("t4b_done", {done, cfg_err}, 2'b11);
    check("t4b_access", wr_cnt + rd_cnt, 0);

    // 5: fill gaps and an ignored start pulse mid-run
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) fill_d[i] = 8'(8'h51 + i * 7);
    load_model(6, 2, 2);
    start_job(6, 2, 2);
    fill(6, 1);
`ifdef IFMAP_SPAD_CTRL_PERF_EN
    check("t5_perf_fill", perf_fill, gap_cnt);
`endif
    check("t5_gaps", gap_cnt, 3);
    fork
      wait_done(0);
      begin
        repeat (3) @(posedge clk);
        #1;
        start = 1; cfg_width = 5'd2; cfg_filt = 5'd1; cfg_reps = 4'd1;
        @(posedge clk);
        #1;
        start = 0;
      end
    join
    end_checks(20, 6);

    // 6: asynchronous reset mid-run, then a clean job
    load_t1();
    start_job(4, 3, 1);
    fill(4, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("t6_rst_out", {busy, done, cfg_err, in_ready, spad_wr, spad_rd, act_valid, act_last, act_end}, 0);
    check("t6_rst_addr", spad_addr, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    load_t1();
    start_job(4, 3, 1);
    fill(4, 0);
    wait_done(0);
    end_checks(6, 4);
`ifdef IFMAP_SPAD_CTRL_PERF_EN
    check("t6_perf_stall", perf_stall, stall_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
